hazard_dest_tracker: RTL and testbench

- Tracks the destination register and live-writer flag of every instruction in EX, MEM and WB.
- Feeds the hazard comparator its `execute`/`memory`/`writeback` register IDs and active-low NOP flags.
- Consumes the comparator's `sendNOP`, inserts bubbles into EX and generates PC / IF-ID hold.
- Keeps saturating performance counters for hazard bubbles and memory-stall cycles.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/hazard_dest_tracker_sat_counter.sv | 30 +++
 rtl/hazard_dest_tracker.sv | 109 ++++++++++
 tb/tb_hazard_dest_tracker.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register width, bubble encoding and the
// active-low NOP flag polarity used by the hazard comparator.
package pipe_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [REG_W-1:0] BUBBLE_DEST = '0;

  localparam logic LIVE = 1'b1;
  localparam logic NOP  = 1'b0;

  localparam logic [15:0] NOP_INST = 16'h0800;

endpackage

// File: rtl/hazard_dest_tracker_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_dest_tracker.sv
// EX/MEM/WB destination tracker: feeds the hazard comparator, inserts bubbles
// on sendNOP, defers flushes across memory stalls, and counts bubbles/stalls.
module hazard_dest_tracker #(
  parameter int unsigned REG_W = pipe_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_valid,
  input  logic             sendNOP,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [REG_W-1:0] execute,
  output logic [REG_W-1:0] memory,
  output logic [REG_W-1:0] writeback,
  output logic             NOPEx,
  output logic             NOPMem,
  output logic             NOPWB,
  output logic             pc_hold,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  import pipe_pkg::*;

  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;
  logic             ex_live_q, ex_live_d;
  logic             mem_live_q, mem_live_d;
  logic             wb_live_q, wb_live_d;
  logic             flush_pend_q, flush_pend_d;
  logic             eff_flush;
  logic             bubble_en;

  // A flush seen during a stall is remembered and applied on the first free edge.
  assign eff_flush = flush | flush_pend_q;
  assign pc_hold   = ~sendNOP & ~eff_flush & ~mem_stall;
  assign bubble_en = ~mem_stall & ~eff_flush & ~sendNOP;

  always_comb begin
    ex_dest_d    = ex_dest_q;
    ex_live_d    = ex_live_q;
    mem_dest_d   = mem_dest_q;
    mem_live_d   = mem_live_q;
    wb_dest_d    = wb_dest_q;
    wb_live_d    = wb_live_q;
    flush_pend_d = 1'b0;
    if (mem_stall) begin
      flush_pend_d = flush_pend_q | flush;
    end else begin
      wb_dest_d  = mem_dest_q;
      wb_live_d  = mem_live_q;
      mem_dest_d = ex_dest_q;
      mem_live_d = ex_live_q;
      if (eff_flush || !sendNOP) begin
        ex_dest_d = REG_W'(BUBBLE_DEST);
        ex_live_d = NOP;
      end else begin
        ex_live_d = (id_valid & id_regwrite) ? LIVE : NOP;
        ex_dest_d = (ex_live_d == LIVE) ? id_dest : REG_W'(BUBBLE_DEST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dest_q    <= '0;
      mem_dest_q   <= '0;
      wb_dest_q    <= '0;
      ex_live_q    <= NOP;
      mem_live_q   <= NOP;
      wb_live_q    <= NOP;
      flush_pend_q <= 1'b0;
    end else begin
      ex_dest_q    <= ex_dest_d;
      mem_dest_q   <= mem_dest_d;
      wb_dest_q    <= wb_dest_d;
      ex_live_q    <= ex_live_d;
      mem_live_q   <= mem_live_d;
      wb_live_q    <= wb_live_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mem_stall),
    .cnt_o (stall_cnt)
  );

  assign execute   = ex_dest_q;
  assign memory    = mem_dest_q;
  assign writeback = wb_dest_q;
  assign NOPEx     = ex_live_q;
  assign NOPMem    = mem_live_q;
  assign NOPWB     = wb_live_q;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Scoreboard bench: a queue-based pipeline model predicts every registered
// output per edge; a monitor pops and compares one edge-worth after each clock.
module tb_hazard_dest_tracker;

  localparam int unsigned REG_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_dest;
  logic             id_regwrite, id_valid, sendNOP, flush, mem_stall;
  logic [REG_W-1:0] execute, memory, writeback;
  logic             NOPEx, NOPMem, NOPWB, pc_hold;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  hazard_dest_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_valid(id_valid), .sendNOP(sendNOP), .flush(flush), .mem_stall(mem_stall),
    .execute(execute), .memory(memory), .writeback(writeback),
    .NOPEx(NOPEx), .NOPMem(NOPMem), .NOPWB(NOPWB), .pc_hold(pc_hold),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dest;
    bit live;
  } ent_t;

  typedef struct {
    int ex, mem, wb;
    bit lex, lmem, lwb;
    int bub, stl;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  ent_t pipe[$];     // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  int   m_bub = 0, m_stl = 0;
  bit   m_fp = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Advance the reference model by one clock edge and queue the predicted outputs.
  task automatic model_edge(input bit r, input int d, input bit rw, input bit v,
                            input bit sn, input bit fl, input bit ms);
    ent_t ne;
    exp_t e;
    ne.dest = 0;
    ne.live = 0;
    if (r) begin
      pipe.delete();
      repeat (3) pipe.push_back(ne);
      m_bub = 0;
      m_stl = 0;
      m_fp  = 0;
    end else if (ms) begin
      if (m_stl < CMAX) m_stl++;
      m_fp = m_fp | fl;
    end else begin
      if (fl || m_fp) begin
        // squashed slot stays a bubble
      end else if (!sn) begin
        if (m_bub < CMAX) m_bub++;
      end else begin
        ne.live = v && rw;
        ne.dest = ne.live ? d : 0;
      end
      m_fp = 0;
      pipe.push_front(ne);
      pipe.delete(3);
    end
    e.ex  = pipe[0].dest; e.lex  = pipe[0].live;
    e.mem = pipe[1].dest; e.lmem = pipe[1].live;
    e.wb  = pipe[2].dest; e.lwb  = pipe[2].live;
    e.bub = m_bub;
    e.stl = m_stl;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input int d, input bit rw, input bit v,
                       input bit sn, input bit fl, input bit ms);
    @(negedge clk);
    rst         = r;
    id_dest     = REG_W'(d);
    id_regwrite = rw;
    id_valid    = v;
    sendNOP     = sn;
    flush       = fl;
    mem_stall   = ms;
    #1;
    chk("pc_hold", int'(pc_hold), int'(!sn && !(fl || m_fp) && !ms));
    model_edge(r, d, rw, v, sn, fl, ms);
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk("execute",    int'(execute),    me.ex);
      chk("memory",     int'(memory),     me.mem);
      chk("writeback",  int'(writeback),  me.wb);
      chk("NOPEx",      int'(NOPEx),      int'(me.lex));
      chk("NOPMem",     int'(NOPMem),     int'(me.lmem));
      chk("NOPWB",      int'(NOPWB),      int'(me.lwb));
      chk("bubble_cnt", int'(bubble_cnt), me.bub);
      chk("stall_cnt",  int'(stall_cnt),  me.stl);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t z;
    z.dest = 0;
    z.live = 0;
    repeat (3) pipe.push_back(z);
    rst = 1'b1; id_dest = '0; id_regwrite = 1'b0; id_valid = 1'b0;
    sendNOP = 1'b1; flush = 1'b0; mem_stall = 1'b0;

    // reset held with a live writer to R5 on the ID inputs, then released
    repeat (2) cycle(1, 5, 1, 1, 1, 0, 0);
    repeat (3) cycle(0, 5, 1, 1, 1, 0, 0);
    // back-to-back writers R1..R3
    for (int i = 1; i <= 3; i++) cycle(0, i, 1, 1, 1, 0, 0);
    // R4 enters EX, then a 3-cycle hazard drains it
    cycle(0, 4, 1, 1, 1, 0, 0);
    repeat (3) cycle(0, 6, 1, 1, 0, 0, 0);
    // 4-cycle memory stall with flush pulsed in stall cycle 2
    cycle(0, 7, 1, 1, 1, 0, 1);
    cycle(0, 7, 1, 1, 1, 1, 1);
    repeat (2) cycle(0, 7, 1, 1, 1, 0, 1);
    repeat (2) cycle(0, 2, 1, 1, 1, 0, 0);
    // flush coinciding with a hazard
    cycle(0, 3, 1, 1, 0, 1, 0);
    // non-writer and invalid slots force EX dest to zero
    cycle(0, 5, 0, 1, 1, 0, 0);
    cycle(0, 6, 1, 0, 1, 0, 0);
    // bubble counter saturation, then reset mid-run
    repeat (20) cycle(0, 1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 1);
    repeat (3) cycle(0, 1, 1, 1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 2);
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
